l2_pipe_arb: RTL and testbench

L2_PIPE_ARB -- requirements
Module: l2_pipe_arb

---
 rtl/l2_pipe_arb_pkg.sv | 22 ++
 rtl/l2_pipe_arb_if.sv | 61 ++++++
 rtl/l2_pipe_arb_credit.sv | 46 ++++
 rtl/l2_pipe_arb.sv | 98 +++++++++
 tb/tb_l2_pipe_arb.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/l2_pipe_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg -- shared definitions for the L2 pipeline arbiter.
//   TYPE_W / TAG_W / SRC_W : message field widths (8 / 26 / 6)
//   SEL_NOC1 / SEL_NOC3    : encoding of the S1 origin select
//   l2_msg_t               : one message (type, tag, src)
// ---------------------------------------------------------------------------
package l2_arb_pkg;

  localparam int TYPE_W = 8;
  localparam int TAG_W  = 26;
  localparam int SRC_W  = 6;

  localparam logic SEL_NOC1 = 1'b0;
  localparam logic SEL_NOC3 = 1'b1;

  typedef struct packed {
    logic [TYPE_W-1:0] mtype;
    logic [TAG_W-1:0]  tag;
    logic [SRC_W-1:0]  src;
  } l2_msg_t;

endpackage

// File: rtl/l2_pipe_arb_if.sv
// ---------------------------------------------------------------------------
// l2_pipe_arb_if -- bundle of every non-clock signal of l2_pipe_arb.
//   NoC1 request channel : noc1_val/rdy, noc1_type/tag/src
//   NoC3 response channel: noc3_val/rdy, noc3_type/tag/src
//   S1 stage             : s1_val, s1_sel, s1_type/tag/src, s1_stall
//   Credit               : commit, inflight, err_underflow
// Modports: slave = arbiter side, master = environment side.
// ---------------------------------------------------------------------------
interface l2_pipe_arb_if
  import l2_arb_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic              noc1_val;
  logic              noc1_rdy;
  logic [TYPE_W-1:0] noc1_type;
  logic [TAG_W-1:0]  noc1_tag;
  logic [SRC_W-1:0]  noc1_src;

  logic              noc3_val;
  logic              noc3_rdy;
  logic [TYPE_W-1:0] noc3_type;
  logic [TAG_W-1:0]  noc3_tag;
  logic [SRC_W-1:0]  noc3_src;

  logic              s1_val;
  logic              s1_sel;
  logic [TYPE_W-1:0] s1_type;
  logic [TAG_W-1:0]  s1_tag;
  logic [SRC_W-1:0]  s1_src;
  logic              s1_stall;

  logic              commit;
  logic [CNT_W-1:0]  inflight;
  logic              err_underflow;

  modport slave (
    input  noc1_val, noc1_type, noc1_tag, noc1_src,
    output noc1_rdy,
    input  noc3_val, noc3_type, noc3_tag, noc3_src,
    output noc3_rdy,
    output s1_val, s1_sel, s1_type, s1_tag, s1_src,
    input  s1_stall,
    input  commit,
    output inflight, err_underflow
  );

  modport master (
    output noc1_val, noc1_type, noc1_tag, noc1_src,
    input  noc1_rdy,
    output noc3_val, noc3_type, noc3_tag, noc3_src,
    input  noc3_rdy,
    input  s1_val, s1_sel, s1_type, s1_tag, s1_src,
    output s1_stall,
    output commit,
    input  inflight, err_underflow
  );

endinterface

// File: rtl/l2_pipe_arb_credit.sv
// ---------------------------------------------------------------------------
// l2_arb_credit -- count of NoC1-originated messages not yet retired.
//   clk, rst        : clock, synchronous active-high reset
//   i_inc           : a NoC1 message was granted this cycle
//   i_commit        : a NoC1 message retired from S4 this cycle
//   o_inflight      : current count (0..MAX_INFLIGHT)
//   o_err_underflow : sticky, set by a commit that had nothing to retire
// ---------------------------------------------------------------------------
module l2_arb_credit #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_inc,
  input  logic                              i_commit,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
  output logic                              o_err_underflow
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case ({i_inc, i_commit})
        2'b10: r_cnt <= r_cnt + 1'b1;
        2'b01: begin
          if (r_cnt == '0) r_err <= 1'b1;
          else             r_cnt <= r_cnt - 1'b1;
        end
        // A commit against an empty counter is absorbed by the grant of the
        // same cycle: the count ends at 1 and no underflow is flagged.
        2'b11: if (r_cnt == '0) r_cnt <= CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_inflight      = r_cnt;
  assign o_err_underflow = r_err;

endmodule

// File: rtl/l2_pipe_arb.sv
// ---------------------------------------------------------------------------
// l2_pipe_arb -- arbitrates NoC1 requests and NoC3 responses into pipeline
// stage S1 of the L2 and caps the number of uncommitted NoC1 messages.
//   clk, rst : clock, synchronous active-high reset
//   bus      : l2_pipe_arb_if.slave (NoC1/NoC3 channels, S1 register
//              outputs, s1_stall, commit, inflight, err_underflow)
// Build option: define L2_PIPE_ARB_STARVE_EN to add the NoC1 anti-starvation
// counter; without it NoC3 has strict priority.
// ---------------------------------------------------------------------------
module l2_pipe_arb
  import l2_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic          clk,
  input  logic          rst,
  l2_pipe_arb_if.slave  bus
);
  localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] w_inflight;
  logic             w_slot_free;
  logic             w_n1_elig;
  logic             w_force1;
  logic             w_gnt1;
  logic             w_gnt3;
  l2_msg_t          w_win_msg;

  logic             r_s1_val_p1;
  logic             r_s1_sel_p1;
  l2_msg_t          r_s1_msg_p1;

  assign w_slot_free = !r_s1_val_p1 || !bus.s1_stall;
  assign w_n1_elig   = bus.noc1_val && (w_inflight < MAX_CNT);

`ifdef L2_PIPE_ARB_STARVE_EN
  localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] r_starve_cnt;

  assign w_force1 = w_n1_elig && (r_starve_cnt == STARVE_MAX);

  // Counts NoC3 wins that NoC1 could have taken; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst)                                               r_starve_cnt <= '0;
    else if (w_gnt1)                                       r_starve_cnt <= '0;
    else if (w_gnt3 && w_n1_elig && r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  assign w_force1 = 1'b0;
`endif

  // Grants are combinational and suppressed during reset.
  assign w_gnt1 = !rst && w_slot_free && (w_force1 || (!bus.noc3_val && w_n1_elig));
  assign w_gnt3 = !rst && w_slot_free && bus.noc3_val && !w_force1;

  always_comb begin
    w_win_msg = '{mtype: bus.noc3_type, tag: bus.noc3_tag, src: bus.noc3_src};
    if (w_gnt1) w_win_msg = '{mtype: bus.noc1_type, tag: bus.noc1_tag, src: bus.noc1_src};
  end

  // ---- S1 register (p1): one cycle after the grant ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_val_p1 <= 1'b0;
      r_s1_sel_p1 <= SEL_NOC1;
      r_s1_msg_p1 <= '0;
    end else if (w_gnt1 || w_gnt3) begin
      r_s1_val_p1 <= 1'b1;
      r_s1_sel_p1 <= w_gnt3 ? SEL_NOC3 : SEL_NOC1;
      r_s1_msg_p1 <= w_win_msg;
    end else if (w_slot_free) begin
      r_s1_val_p1 <= 1'b0;
    end
  end

  l2_arb_credit #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_credit (
    .clk             (clk),
    .rst             (rst),
    .i_inc           (w_gnt1),
    .i_commit        (bus.commit),
    .o_inflight      (w_inflight),
    .o_err_underflow (bus.err_underflow)
  );

  assign bus.noc1_rdy = w_gnt1;
  assign bus.noc3_rdy = w_gnt3;
  assign bus.s1_val   = r_s1_val_p1;
  assign bus.s1_sel   = r_s1_sel_p1;
  assign bus.s1_type  = r_s1_msg_p1.mtype;
  assign bus.s1_tag   = r_s1_msg_p1.tag;
  assign bus.s1_src   = r_s1_msg_p1.src;
  assign bus.inflight = w_inflight;

endmodule

// File: tb/tb_l2_pipe_arb.sv
// ---------------------------------------------------------------------------
// tb_l2_pipe_arb -- scoreboard bench for l2_pipe_arb. The driver applies
// directed scenarios followed by random traffic, predicts each cycle's
// grants and the following S1/credit state from a behavioural model, and
// queues the expectations; two monitors pop and compare them.
// ---------------------------------------------------------------------------
module tb_l2_pipe_arb;
  import l2_arb_pkg::*;

  localparam int LIMIT = 4;
  localparam int MAXF  = 4;

  typedef struct { bit r1; bit r3; } rdy_exp_t;
  typedef struct {
    int val; int sel; int mtype; int tag; int src; int inf; int err;
  } st_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_pipe_arb_if #(.MAX_INFLIGHT(MAXF)) bus ();

  l2_pipe_arb #(.STARVE_LIMIT(LIMIT), .MAX_INFLIGHT(MAXF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rdy_exp_t q_rdy[$];
  st_exp_t  q_st[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int m_val = 0, m_sel = 0, m_type = 0, m_tag = 0, m_src = 0;
  int m_starve = 0, m_inf = 0, m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // One cycle of stimulus plus its prediction.
  task automatic step(input bit r, input bit n1v, input bit n3v, input bit stall,
                      input bit cm, input bit keep = 1'b0);
    bit slot, elig, force1, g1, g3;
    rdy_exp_t re;
    st_exp_t  se;
    @(posedge clk);
    #2;
    rst          = r;
    bus.noc1_val = n1v;
    bus.noc3_val = n3v;
    bus.s1_stall = stall;
    bus.commit   = cm;
    if (!keep) begin
      bus.noc1_type = 8'($urandom);
      bus.noc1_tag  = 26'($urandom);
      bus.noc1_src  = 6'($urandom);
    end
    bus.noc3_type = 8'($urandom);
    bus.noc3_tag  = 26'($urandom);
    bus.noc3_src  = 6'($urandom);

    slot = (m_val == 0) || !stall;
    elig = n1v && (m_inf < MAXF);
`ifdef L2_PIPE_ARB_STARVE_EN
    force1 = (m_starve == LIMIT) && elig;
`else
    force1 = 1'b0;
`endif
    g1 = 1'b0;
    g3 = 1'b0;
    if (!r && slot) begin
      if (force1)    g1 = 1'b1;
      else if (n3v)  g3 = 1'b1;
      else if (elig) g1 = 1'b1;
    end
    re.r1 = g1;
    re.r3 = g3;
    q_rdy.push_back(re);

    if (r) begin
      m_val = 0; m_sel = 0; m_type = 0; m_tag = 0; m_src = 0;
      m_starve = 0; m_inf = 0; m_err = 0;
    end else begin
      if (g1) begin
        m_val = 1; m_sel = 0;
        m_type = int'(bus.noc1_type); m_tag = int'(bus.noc1_tag); m_src = int'(bus.noc1_src);
      end else if (g3) begin
        m_val = 1; m_sel = 1;
        m_type = int'(bus.noc3_type); m_tag = int'(bus.noc3_tag); m_src = int'(bus.noc3_src);
      end else if (slot) begin
        m_val = 0;
      end
      if (g1) m_starve = 0;
      else if (g3 && elig && m_starve < LIMIT) m_starve++;
      if (cm) begin
        if (m_inf == 0) begin
          if (!g1) m_err = 1;
        end else begin
          m_inf--;
        end
      end
      if (g1) m_inf++;
    end
    se = '{m_val, m_sel, m_type, m_tag, m_src, m_inf, m_err};
    q_st.push_back(se);
  endtask

  // grant monitor: inputs and state are stable at the falling edge
  initial begin
    rdy_exp_t e;
    forever begin
      @(negedge clk);
      if (q_rdy.size() > 0) begin
        e = q_rdy.pop_front();
        chk("noc1_rdy", 32'(bus.noc1_rdy), 32'(e.r1));
        chk("noc3_rdy", 32'(bus.noc3_rdy), 32'(e.r3));
      end
    end
  end

  // state monitor: just after each rising edge
  initial begin
    st_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_st.size() > 0) begin
        e = q_st.pop_front();
        chk("s1_val",   32'(bus.s1_val),   32'(e.val));
        chk("s1_sel",   32'(bus.s1_sel),   32'(e.sel));
        chk("s1_type",  32'(bus.s1_type),  32'(e.mtype));
        chk("s1_tag",   32'(bus.s1_tag),   32'(e.tag));
        chk("s1_src",   32'(bus.s1_src),   32'(e.src));
        chk("inflight", 32'(bus.inflight), 32'(e.inf));
        chk("err_underflow", 32'(bus.err_underflow), 32'(e.err));
      end
    end
  end

  initial begin
    bus.noc1_val = 0; bus.noc3_val = 0; bus.s1_stall = 0; bus.commit = 0;
    bus.noc1_type = 0; bus.noc1_tag = 0; bus.noc1_src = 0;
    bus.noc3_type = 0; bus.noc3_tag = 0; bus.noc3_src = 0;

    repeat (3) step(1, 0, 0, 0, 0);

    // single NoC1 message with fixed fields, then let it drain
    bus.noc1_type = 8'h31;
    bus.noc1_tag  = 26'h155AA;
    bus.noc1_src  = 6'd3;
    step(0, 1, 0, 0, 0, 1'b1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // both requesters held: starvation pattern (or strict NoC3)
    repeat (12) step(0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);

    // fill the credit window, NoC3 still served, one commit reopens it
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0);

    // stall with both valid for three cycles
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);

    // underflow, then commit coinciding with a NoC1 grant at inflight 2
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // reset with a live S1 message and three in flight
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(posedge clk);
    #3;
    chk("rdy_queue_left", 32'(q_rdy.size()), 32'd0);
    chk("st_queue_left",  32'(q_st.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
